// File: rtl/uart_tx_port.sv
// uart_tx_port: 8N1 UART transmitter fed by a small circular FIFO.
//   clk, reset   : clock (rising edge) and asynchronous active-high reset
//   we, wd       : CPU write strobe and data byte; a write while full is dropped
//   clr_ovf      : clears the sticky overflow flag (a new overflow wins)
//   tx           : registered serial output, idle high
//   busy         : a frame is on the line
//   count        : FIFO occupancy; full/empty decoded from it
//   ovf          : sticky flag, a write was attempted while full
// A frame is start + 8 data bits (LSB first) + stop, each DIV clk cycles.
// Back-to-back frames chain straight from STOP into START with no gap.
module uart_tx_port #(
   parameter int DIV   = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [7:0]                 wd,
   input  logic                       clr_ovf,
   output logic                       tx,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0] BAUD_LAST = 8'(DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [7:0]      baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            ovf_q, ovf_d;
   logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];

   logic            push, pop, have, baud_last;

   always_comb begin
      full      = (count_q == CW'(DEPTH));
      empty     = (count_q == '0);
      have      = !empty;
      baud_last = (baud_q == BAUD_LAST);
      push      = we & ~full;
      pop       = 1'b0;

      state_d = state_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      // Counter free-runs 0..DIV-1 in every active state; transitions only
      // occur at the wrap (or out of IDLE), so it is 0 on each state entry.
      baud_d  = (state_q == IDLE || baud_last) ? 8'd0 : baud_q + 8'd1;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (have) begin
               pop     = 1'b1;
               shreg_d = mem_q[rp_q];
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: if (baud_last) begin
            state_d = DATA;
            bit_d   = 3'd0;
            tx_d    = shreg_q[0];
         end
         DATA: if (baud_last) begin
            if (bit_q == 3'd7) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               bit_d   = bit_q + 3'd1;
               shreg_d = shreg_q >> 1;
               tx_d    = shreg_q[1];
            end
         end
         STOP: if (baud_last) begin
            if (have) begin
               pop     = 1'b1;
               shreg_d = mem_q[rp_q];
               state_d = START;
               tx_d    = 1'b0;
            end else begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Full is judged on the pre-edge count, so a same-cycle pop never
      // rescues a write into a full FIFO.
      ovf_d   = (we & full) | (ovf_q & ~clr_ovf);
      wp_d    = wp_q + AW'(push);
      rp_d    = rp_q + AW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
      mem_d   = mem_q;
      if (push) mem_d[wp_q] = wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign tx    = tx_q;
   assign busy  = (state_q != IDLE);
   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomized + directed bench for uart_tx_port (DIV=4, DEPTH=4) against a
// cycle-level model: a byte queue plus a frame timer whose tx value is
// looked up from the frame position.
module tb_uart_tx_port;
  localparam int DIV = 4, DEPTH = 4, CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, reset = 1'b1, we = 1'b0, clr_ovf = 1'b0;
  logic [7:0] wd = 8'h00;
  logic tx, busy, full, empty, ovf;
  logic [CW-1:0] count;

  uart_tx_port #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .wd(wd), .clr_ovf(clr_ovf),
    .tx(tx), .busy(busy), .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int busy_cycles = 0, peak_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  logic [7:0] q[$];
  logic [7:0] cur;
  bit m_act = 0, m_ovf = 0;
  int m_t = 0;

  function automatic logic m_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_t / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete(); m_act = 0; m_t = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit w, input logic [7:0] d, input bit c);
    int cnt = q.size();
    bit full_pre = (cnt == DEPTH);
    if (m_act) begin
      m_t++;
      if (m_t == 10*DIV) begin
        if (cnt != 0) begin cur = q.pop_front(); m_t = 0; end
        else m_act = 0;
      end
    end else if (cnt != 0) begin
      cur = q.pop_front(); m_act = 1; m_t = 0;
    end
    if (w && !full_pre) q.push_back(d);
    m_ovf = (w && full_pre) || (m_ovf && !c);
  endtask

  task automatic check_all();
    chk("tx",    32'(tx),    32'(m_tx()));
    chk("busy",  32'(busy),  32'(m_act));
    chk("count", 32'(count), 32'(q.size()));
    chk("full",  32'(full),  32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("ovf",   32'(ovf),   32'(m_ovf));
  endtask

  task automatic tick(input bit w, input logic [7:0] d, input bit c);
    we = w; wd = d; clr_ovf = c;
    @(posedge clk);
    model_edge(w, d, c);
    #1;
    check_all();
    if (busy === 1'b1) busy_cycles++;
    if (int'(count) > peak_cnt) peak_cnt = int'(count);
    we = 1'b0; clr_ovf = 1'b0;
  endtask

  // Asserted mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_tx_now", 32'(tx), 32'd1);
    check_all();
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("por_tx", 32'(tx), 32'd1);
    chk("por_empty", 32'(empty), 32'd1);
    check_all();
    @(negedge clk) reset = 1'b0;

    // idle after reset
    repeat (100) tick(0, 8'h00, 0);

    // single 0xA5 frame
    busy_cycles = 0;
    tick(1, 8'hA5, 0);
    chk("a5_count", 32'(count), 32'd1);
    tick(0, 8'h00, 0);
    chk("a5_start_tx", 32'(tx), 32'd0);
    repeat (48) tick(0, 8'h00, 0);
    chk("a5_busy_cycles", 32'(busy_cycles), 32'd40);

    // three back-to-back frames
    busy_cycles = 0; peak_cnt = 0;
    tick(1, 8'h01, 0); tick(1, 8'h02, 0); tick(1, 8'h03, 0);
    repeat (130) tick(0, 8'h00, 0);
    chk("b2b_busy_cycles", 32'(busy_cycles), 32'd120);
    chk("b2b_peak_count", 32'(peak_cnt), 32'd2);

    // overflow on sixth write, then clear
    for (int i = 0; i < 6; i++) tick(1, 8'(8'h10 + i), 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_set", 32'(ovf), 32'd1);
    tick(0, 8'h00, 1);
    chk("ovf_cleared", 32'(ovf), 32'd0);
    // overflow and clear on the same edge: overflow wins
    tick(1, 8'h77, 1);
    chk("ovf_vs_clr", 32'(ovf), 32'd1);
    tick(0, 8'h00, 1);
    repeat (220) tick(0, 8'h00, 0);

    // reset mid-frame with two bytes queued
    tick(1, 8'h11, 0); tick(1, 8'h22, 0); tick(1, 8'h33, 0);
    repeat (13) tick(0, 8'h00, 0);
    chk("pre_rst_count", 32'(count), 32'd2);
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    busy_cycles = 0;
    repeat (60) tick(0, 8'h00, 0);
    chk("rst_no_frames", 32'(busy_cycles), 32'd0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      tick($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
